// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: streams sequential words out of a combinational ROM
// into a small {pc, inst} FIFO and hands them to the IF stage over valid/ready.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic [1:0]  dbg_state
);

    // Handshake: a head entry transfers on every rising edge where
    // if_valid_o & if_ready_i; if_valid_o never depends on if_ready_i and
    // the head stays stable until it transfers (or a redirect/reset flushes it).

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (count != '0);

    // Fetch enable depends only on registered state and redirect, never on if_ready_i.
    assign push       = (state == RUN) & ~redirect_i & ~rst;
    assign rom_ce_o   = push;
    assign rom_addr_o = rst ? 32'h0 : fetch_pc;

    assign if_valid_o = not_empty & ~redirect_i & ~rst;
    assign pop        = if_valid_o & if_ready_i;
    assign if_pc_o    = (not_empty & ~rst) ? pc_mem[head]   : 32'h0;
    assign if_inst_o  = (not_empty & ~rst) ? inst_mem[head] : 32'h0;

    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        count_next = count;
        if (redirect_i) begin
            state_next = RUN;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = RUN;
                end
                RUN, HOLD: begin
                    case ({push, pop})
                        2'b10:   count_next = count + 1'b1;
                        2'b01:   count_next = count - 1'b1;
                        default: count_next = count;
                    endcase
                    state_next = (count_next == FULL) ? HOLD : RUN;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_i) begin
                head     <= '0;
                tail     <= '0;
                fetch_pc <= redirect_addr_i & 32'hFFFF_FFFC;
            end else begin
                if (push) begin
                    tail     <= tail + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= rom_data_i;
        end
    end

endmodule
